pwm_multi: RTL and testbench
============================

// Module: pwm_multi
// PURPOSE
//  Multi-channel PWM generator: one shared period counter with prescaler, NCH compare channels.
//  Double-buffered (shadow) period/duty/mode; new settings commit only at period boundaries, so no runt pulses.
//  Supports edge- and center-aligned modes.
//  Drives motor/LED/servo outputs; the cfg bus is written by the control FSM or register file.
// PARAMETERS
//  NCH      4   number of PWM channels
//  WIDTH    8   bits of counter, period and each duty
//  PRESC_W  8   bits of prescaler setting
// PORTS
//  clk         in   1            system clock, all logic on rising edge
//  rst_n       in   1            synchronous reset, active low
//  en          in   1            1 = run; 0 = counter/prescaler held at 0, outputs idle
//  prescale    in   PRESC_W      counter advances once every prescale+1 clk
//  period      in   WIDTH        shadow input: counter top value
//  duty        in   NCH*WIDTH    shadow input: channel i duty = duty[i*WIDTH +: WIDTH]
//  center      in   1            shadow input: 0 = edge-aligned, 1 = center-aligned
//  inv         in   NCH          per-channel output inversion, applied combinationally before the output register
//  cfg_load    in   1            1-clk strobe: capture period/duty/center into shadow regs
//  pwm_out     out  NCH          registered PWM outputs
//  period_end  out  1            1-clk pulse on each period boundary
//  upd_pending out  1            shadow captured, not yet committed to active regs
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - cnt=0, dir=up, prescaler=0; shadow and active regs all 0.
//   - pwm_out=0 (inv not applied during reset); period_end=0; upd_pending=0.
//  Tick: prescaler counts 0..prescale; tick=1 when it equals prescale, then it wraps to 0.
//   - prescale=0 gives a tick every clk. cnt changes only on tick.
//  Edge mode: cnt 0,1,...,P,0 (P = active period); period = (P+1) ticks.
//   - Boundary = tick with cnt==P.
//  Center mode: cnt counts up to P, then down to 0, then up (no repeated endpoints); period = 2P ticks.
//   - Boundary = tick with cnt==0 and dir=down.
//   - P=0: cnt stays 0; boundary on every tick.
//  Compare: raw_i = (cnt < D_i), unsigned WIDTH-bit compare.
//   - pwm_out[i] <= raw_i ^ inv[i], 1-clk latency from cnt.
//   - D_i=0 -> constant 0% duty; D_i>P -> constant 100% duty (no glitch at wrap).
//   - Edge mode high time = min(D_i, P+1) ticks. Center mode high time = 2*D_i-1 ticks for 1<=D_i<=P.
//  Shadow/commit:
//   - cfg_load=1: shadow <= inputs; upd_pending <= 1.
//   - At boundary with upd_pending=1: active <= shadow, upd_pending <= 0; cnt restarts at 0, dir=up.
//   - cfg_load coinciding with boundary: inputs go directly to active that cycle; upd_pending ends 0.
//   - cfg_load while pending: shadow overwritten; last write wins.
//   - en=0: cfg_load commits immediately (no pending).
//  period_end: asserted the clk after the boundary tick for 1 clk; never asserted while en=0.
//  en falling: next clk cnt=0, prescaler=0, dir=up, pwm_out=inv (idle level).
//  en rising: counting restarts from cnt=0 with the active config.
//  Reset mid-period: all state returns to reset values on the same edge; pending update is discarded.
//  prescale changes take effect immediately; the prescaler compare uses ==.
//   - prescaler > new prescale: it runs on to its max value, wraps, then compares normally.
//   - Firmware changes prescale only with en=0.
// TESTING
//  1. Reset, en=1, prescale=0, period=9, duty[0]=3, cfg_load -> out0 high 3 clk / low 7 clk; period_end every 10 clk.
//  2. duty[1]=0, duty[2]=10, duty[3]=255 with period=9 -> out1 always 0; out2 and out3 always 1, no glitch at wrap.
//  3. Mid-period cfg_load duty[0]=7 -> waveform unchanged until period_end; next period high 7 clk.
//     upd_pending is 1 until the commit.
//  4. center=1, period=4, duty[0]=2 -> 8-clk period, out0 high 3 clk centered on cnt==0; inv[0]=1 -> complement.
//  5. prescale=2, period=3, duty=2 -> cnt steps every 3 clk; period 12 clk, high 6 clk.
//     en=0 -> out=inv next clk, period_end silent.
//  6. rst_n=0 mid-period with upd_pending=1 -> next clk all outputs 0, pending cleared, active regs 0.

Source files
------------

// File: rtl/pwm_multi_if.sv
// pwm_multi_if: control/config inputs and PWM status outputs of pwm_multi
interface pwm_multi_if #(parameter int NCH = 4, parameter int WIDTH = 8, parameter int PRESC_W = 8);
  logic en;
  logic [PRESC_W-1:0] prescale;
  logic [WIDTH-1:0] period;
  logic [NCH*WIDTH-1:0] duty;
  logic center;
  logic [NCH-1:0] inv;
  logic cfg_load;
  logic [NCH-1:0] pwm_out;
  logic period_end;
  logic upd_pending;
  modport master(output en, prescale, period, duty, center, inv, cfg_load,
                 input pwm_out, period_end, upd_pending);
  modport slave(input en, prescale, period, duty, center, inv, cfg_load,
                output pwm_out, period_end, upd_pending);
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: shared prescaled counter, NCH compare channels, shadowed period/duty/mode
module pwm_multi #(parameter int NCH = 4, parameter int WIDTH = 8, parameter int PRESC_W = 8) (
  input logic clk,
  input logic rst_n,
  pwm_multi_if.slave bus
);
  typedef enum logic {UP, DOWN} dir_t;
  logic [PRESC_W-1:0] r_psc;
  logic [WIDTH-1:0] r_cnt, r_per, r_sh_per;
  logic [NCH*WIDTH-1:0] r_duty, r_sh_duty;
  logic r_ctr, r_sh_ctr, r_pend, r_pe;
  logic [NCH-1:0] r_out;
  dir_t r_dir;
  logic w_tick, w_bnd, w_direct, w_commit;
  logic [NCH-1:0] w_raw;
  assign w_tick = bus.en && r_psc == bus.prescale;
  // center mode with P=0 never leaves cnt=0, so every tick is a boundary
  assign w_bnd = w_tick && (r_ctr ? r_cnt == '0 && (r_dir == DOWN || r_per == '0) : r_cnt == r_per);
  assign w_direct = bus.cfg_load && (w_bnd || !bus.en);
  assign w_commit = w_bnd && (bus.cfg_load || r_pend);
  for (genvar i = 0; i < NCH; i++) begin : g_cmp
    assign w_raw[i] = r_cnt < r_duty[i*WIDTH +: WIDTH];
  end
  assign bus.pwm_out = r_out;
  assign bus.period_end = r_pe;
  assign bus.upd_pending = r_pend;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_psc <= '0;
      r_cnt <= '0;
      r_dir <= UP;
      r_per <= '0;
      r_sh_per <= '0;
      r_duty <= '0;
      r_sh_duty <= '0;
      r_ctr <= 1'b0;
      r_sh_ctr <= 1'b0;
      r_pend <= 1'b0;
      r_pe <= 1'b0;
      r_out <= '0;
    end else begin
      r_pe <= w_bnd;
      r_out <= bus.en ? w_raw ^ bus.inv : bus.inv;
      if (bus.cfg_load) begin
        r_sh_per <= bus.period;
        r_sh_duty <= bus.duty;
        r_sh_ctr <= bus.center;
      end
      if (w_direct) begin
        r_per <= bus.period;
        r_duty <= bus.duty;
        r_ctr <= bus.center;
        r_pend <= 1'b0;
      end else if (bus.cfg_load) begin
        r_pend <= 1'b1;
      end else if (w_commit) begin
        r_per <= r_sh_per;
        r_duty <= r_sh_duty;
        r_ctr <= r_sh_ctr;
        r_pend <= 1'b0;
      end
      if (!bus.en) begin
        r_psc <= '0;
        r_cnt <= '0;
        r_dir <= UP;
      end else begin
        r_psc <= w_tick ? '0 : r_psc + 1'b1;
        if (w_commit) begin
          r_cnt <= '0;
          r_dir <= UP;
        end else if (w_tick) begin
          if (!r_ctr) begin
            r_cnt <= r_cnt == r_per ? '0 : r_cnt + 1'b1;
          end else if (r_per == '0) begin
            r_cnt <= '0;
            r_dir <= UP;
          end else if (r_dir == UP) begin
            r_dir <= r_cnt >= r_per ? DOWN : UP;
            r_cnt <= r_cnt >= r_per ? r_cnt - 1'b1 : r_cnt + 1'b1;
          end else begin
            r_dir <= r_cnt == '0 ? UP : DOWN;
            r_cnt <= r_cnt == '0 ? WIDTH'(1) : r_cnt - 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed + random stimulus against a period-position reference model
module tb_pwm_multi;
  localparam int NCH = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  int m_pos, m_div, a_per, s_per;
  int a_duty[NCH];
  int s_duty[NCH];
  bit a_ctr, s_ctr, m_pend, e_pe;
  logic [NCH-1:0] e_out;
  always #5 clk = ~clk;
  pwm_multi_if #(.NCH(NCH), .WIDTH(W), .PRESC_W(8)) bus();
  pwm_multi #(.NCH(NCH), .WIDTH(W), .PRESC_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // edge mode: position is the count; center mode: position walks 0..2P, count folds at P
  function automatic int cnt_of();
    return a_ctr ? (m_pos <= a_per ? m_pos : 2 * a_per - m_pos) : m_pos;
  endfunction
  task automatic model_step();
    bit tick, bnd;
    int c;
    if (!rst_n) begin
      m_pos = 0; m_div = 0; a_per = 0; s_per = 0; a_ctr = 0; s_ctr = 0;
      m_pend = 0; e_out = '0; e_pe = 0;
      for (int i = 0; i < NCH; i++) begin a_duty[i] = 0; s_duty[i] = 0; end
      return;
    end
    tick = bus.en && m_div == int'(bus.prescale);
    bnd = tick && (a_ctr ? (a_per == 0 || m_pos == 2 * a_per) : m_pos == a_per);
    c = cnt_of();
    for (int i = 0; i < NCH; i++) e_out[i] = bus.en ? ((c < a_duty[i]) ^ bus.inv[i]) : bus.inv[i];
    e_pe = bnd;
    if (!bus.en) begin
      m_pos = 0; m_div = 0;
    end else begin
      m_div = tick ? 0 : (m_div + 1) % 256;
      if (tick) m_pos = bnd ? ((a_ctr && a_per != 0) ? 1 : 0) : m_pos + 1;
    end
    if (bus.cfg_load) begin
      s_per = bus.period; s_ctr = bus.center;
      for (int i = 0; i < NCH; i++) s_duty[i] = bus.duty[i*W +: W];
      if (bnd || !bus.en) begin
        a_per = s_per; a_ctr = s_ctr; a_duty = s_duty; m_pend = 0; m_pos = 0;
      end else m_pend = 1;
    end else if (bnd && m_pend) begin
      a_per = s_per; a_ctr = s_ctr; a_duty = s_duty; m_pend = 0; m_pos = 0;
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("pwm_out", 32'(bus.pwm_out), 32'(e_out));
    check("period_end", 32'(bus.period_end), 32'(e_pe));
    check("upd_pending", 32'(bus.upd_pending), 32'(m_pend));
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic cfg(input int per, input int d0, input int d1, input int d2, input int d3, input bit ctr);
    bus.period = W'(per); bus.center = ctr;
    bus.duty = {W'(d3), W'(d2), W'(d1), W'(d0)};
    bus.cfg_load = 1'b1;
    step();
    bus.cfg_load = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0; bus.prescale = '0; bus.period = '0; bus.duty = '0;
    bus.center = 1'b0; bus.inv = '0; bus.cfg_load = 1'b0;
    run(2);
    rst_n = 1'b1; bus.en = 1'b1;
    cfg(9, 3, 0, 10, 255, 0);
    run(30);
    cfg(9, 7, 0, 10, 255, 0);
    run(25);
    cfg(4, 2, 1, 4, 5, 1);
    run(20);
    bus.inv = 4'b0001;
    run(20);
    bus.en = 1'b0; bus.inv = '0;
    step();
    bus.prescale = 8'd2;
    cfg(3, 2, 0, 3, 4, 0);
    bus.en = 1'b1;
    run(30);
    bus.inv = 4'b1010; bus.en = 1'b0;
    run(5);
    bus.en = 1'b1;
    run(4);
    cfg(6, 1, 2, 3, 4, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(10);
    repeat (3000) begin
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 39) == 0) bus.en = ~bus.en;
      if (!bus.en && $urandom_range(0, 3) == 0) bus.prescale = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) bus.inv = 4'($urandom);
      bus.cfg_load = ($urandom_range(0, 19) == 0);
      if (bus.cfg_load) begin
        bus.period = W'($urandom_range(0, 12));
        bus.center = 1'($urandom);
        for (int i = 0; i < NCH; i++)
          bus.duty[i*W +: W] = ($urandom_range(0, 9) == 0) ? 8'd255 : W'($urandom_range(0, 14));
      end
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
